// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, sequencer state encoding and
// branch-opcode classification.
package cpu_pkg;

  localparam logic [4:0] OP_BGT = 5'b01101;
  localparam logic [4:0] OP_BEQ = 5'b01110;
  localparam logic [4:0] OP_BGE = 5'b01111;
  localparam logic [4:0] OP_BLT = 5'b10000;
  localparam logic [4:0] OP_BLE = 5'b10001;
  localparam logic [4:0] OP_BRN = 5'b10010;
  localparam logic [4:0] OP_HLT = 5'b11111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_BRCHK,
    ST_HALT
  } state_t;

  // Branch opcodes occupy one contiguous range, BGT..BRN.
  function automatic logic is_branch(input logic [4:0] op);
    return (op >= OP_BGT) && (op <= OP_BRN);
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Instruction sequencer: owns the PC, fetches opcodes, issues to execute,
// drives the branch unit for one cycle per branch and counts retirements.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [4:0]        imem_opcode,
  output logic              exec_valid,
  output logic [4:0]        exec_op,
  input  logic              exec_ready,
  output logic              br_en,
  output logic              br_hold,
  output logic [4:0]        br_op,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [31:0]       instret
);

  state_t            state, state_nxt;
  logic [4:0]        ir;
  logic              ir_load;
  logic [ADDR_W-1:0] pc_nxt;
  logic [31:0]       instret_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pc      <= RESET_PC;
      ir      <= '0;
      instret <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      instret <= instret_nxt;
      if (ir_load) ir <= imem_opcode;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    instret_nxt = instret;
    ir_load     = 1'b0;
    imem_req    = 1'b0;
    exec_valid  = 1'b0;
    exec_op     = '0;
    br_en       = 1'b0;
    br_hold     = 1'b0;
    br_op       = '0;
    busy        = 1'b0;
    halted      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (halt_req)   state_nxt = ST_HALT;
        else if (start) state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        busy     = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          if (imem_opcode == OP_HLT) begin
            state_nxt   = ST_HALT;
            instret_nxt = instret + 32'd1;
          end else if (is_branch(imem_opcode)) begin
            state_nxt = ST_BRCHK;
          end else begin
            state_nxt = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        exec_valid = 1'b1;
        exec_op    = ir;
        busy       = 1'b1;
        if (exec_ready) begin
          pc_nxt      = pc + ADDR_W'(1);
          instret_nxt = instret + 32'd1;
          state_nxt   = halt_req ? ST_HALT : ST_FETCH;
        end
      end

      ST_BRCHK: begin
        br_en       = 1'b1;
        br_hold     = 1'b1;
        br_op       = ir;
        busy        = 1'b1;
        pc_nxt      = br_taken ? br_addr : pc + ADDR_W'(1);
        instret_nxt = instret + 32'd1;
        state_nxt   = halt_req ? ST_HALT : ST_FETCH;
      end

      ST_HALT: begin
        halted = 1'b1;
        if (start) state_nxt = ST_FETCH;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign imem_addr = pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer against an
// instruction-level model of PC, retirement count and handshake timing.
module tb_pc_sequencer;
  import cpu_pkg::*;

  localparam int unsigned AW  = 16;
  localparam logic [15:0] RPC = 16'h0010;

  logic          clk, rst_n, start, halt_req;
  logic          imem_req, imem_ack;
  logic [AW-1:0] imem_addr;
  logic [4:0]    imem_opcode;
  logic          exec_valid, exec_ready;
  logic [4:0]    exec_op;
  logic          br_en, br_hold, br_taken;
  logic [4:0]    br_op;
  logic [AW-1:0] br_addr, pc;
  logic          busy, halted;
  logic [31:0]   instret;

  pc_sequencer #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_opcode(imem_opcode), .exec_valid(exec_valid), .exec_op(exec_op),
    .exec_ready(exec_ready), .br_en(br_en), .br_hold(br_hold), .br_op(br_op),
    .br_taken(br_taken), .br_addr(br_addr), .pc(pc), .busy(busy),
    .halted(halted), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [15:0] m_pc;
  logic [31:0] m_ret;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered at a negedge with the DUT expected in FETCH at m_pc.
  task automatic run_instr(input logic [4:0] op, input int unsigned ack_dly,
                           input int unsigned rdy_dly, input logic taken,
                           input logic [15:0] tgt, input logic hreq);
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
    chk("pre_br_hold", 32'(br_hold), 32'd0);
    chk("pre_br_en", 32'(br_en), 32'd0);
    for (int i = 0; i < int'(ack_dly); i++) begin
      imem_ack    = 1'b0;
      imem_opcode = 5'($urandom);
      exec_ready  = 1'($urandom_range(0, 1));
      tick();
      chk("stall_req", 32'(imem_req), 32'd1);
      chk("stall_addr", 32'(imem_addr), 32'(m_pc));
      chk("stall_no_exec", 32'(exec_valid), 32'd0);
    end
    exec_ready  = 1'b0;
    imem_ack    = 1'b1;
    imem_opcode = op;
    tick();
    imem_ack    = 1'b0;
    imem_opcode = 5'($urandom);

    if (op == OP_HLT) begin
      m_ret++;
      chk("hlt_halted", 32'(halted), 32'd1);
      chk("hlt_req", 32'(imem_req), 32'd0);
      chk("hlt_pc", 32'(pc), 32'(m_pc));
      chk("hlt_instret", instret, m_ret);
      return;
    end

    if (is_branch(op)) begin
      chk("br_en", 32'(br_en), 32'd1);
      chk("br_hold", 32'(br_hold), 32'd1);
      chk("br_op", 32'(br_op), 32'(op));
      chk("br_no_exec", 32'(exec_valid), 32'd0);
      br_taken = taken;
      br_addr  = taken ? tgt : 16'($urandom);
      halt_req = hreq;
      imem_ack = 1'($urandom_range(0, 1));
      tick();
      br_taken = 1'b0;
      halt_req = 1'b0;
      imem_ack = 1'b0;
      m_pc = taken ? tgt : m_pc + 16'd1;
      m_ret++;
      chk("br_en_after", 32'(br_en), 32'd0);
      chk("br_hold_after", 32'(br_hold), 32'd0);
    end else begin
      chk("exec_valid", 32'(exec_valid), 32'd1);
      chk("exec_op", 32'(exec_op), 32'(op));
      chk("issue_br_hold", 32'(br_hold), 32'd0);
      for (int i = 0; i < int'(rdy_dly); i++) begin
        exec_ready = 1'b0;
        halt_req   = hreq;
        imem_ack   = 1'($urandom_range(0, 1));
        tick();
        chk("issue_stall_valid", 32'(exec_valid), 32'd1);
        chk("issue_stall_op", 32'(exec_op), 32'(op));
        chk("issue_stall_halted", 32'(halted), 32'd0);
        chk("issue_stall_pc", 32'(pc), 32'(m_pc));
      end
      imem_ack   = 1'b0;
      exec_ready = 1'b1;
      halt_req   = hreq;
      tick();
      exec_ready = 1'b0;
      halt_req   = 1'b0;
      m_pc++;
      m_ret++;
      chk("exec_valid_after", 32'(exec_valid), 32'd0);
    end
    chk("pc", 32'(pc), 32'(m_pc));
    chk("instret", instret, m_ret);
    chk("halted", 32'(halted), 32'(hreq));
    chk("next_req", 32'(imem_req), 32'(!hreq));
  endtask

  // halt_req is randomly asserted alongside start: it must be ignored in HALT.
  task automatic resume();
    chk("resume_halted", 32'(halted), 32'd1);
    start    = 1'b1;
    halt_req = 1'($urandom_range(0, 1));
    tick();
    start    = 1'b0;
    halt_req = 1'b0;
    chk("resume_not_halted", 32'(halted), 32'd0);
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", 32'(imem_addr), 32'(m_pc));
  endtask

  initial begin
    logic [4:0] op;
    logic       hreq;
    int unsigned r;

    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; imem_ack = 1'b0;
    imem_opcode = '0; exec_ready = 1'b0; br_taken = 1'b0; br_addr = '0;
    tick();
    tick();
    chk("rst_pc", 32'(pc), 32'(RPC));
    chk("rst_instret", instret, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_br_hold", 32'(br_hold), 32'd0);
    chk("rst_exec_op", 32'(exec_op), 32'd0);
    rst_n = 1'b1;
    m_pc  = RPC;
    m_ret = '0;

    // Stray handshakes in IDLE must not move anything.
    imem_ack = 1'b1; exec_ready = 1'b1; imem_opcode = OP_HLT;
    tick();
    imem_ack = 1'b0; exec_ready = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_halted", 32'(halted), 32'd0);
    chk("idle_instret", instret, 32'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    run_instr(5'h01, 0, 0, 1'b0, '0, 1'b0);
    run_instr(5'h02, 0, 0, 1'b0, '0, 1'b0);
    run_instr(5'h03, 0, 0, 1'b0, '0, 1'b0);
    chk("line_pc", 32'(pc), 32'(RPC + 16'd3));

    // Asynchronous reset while a fetch is pending.
    chk("mid_fetch_req", 32'(imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pc", 32'(pc), 32'(RPC));
    chk("async_req", 32'(imem_req), 32'd0);
    chk("async_instret", instret, 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc  = RPC;
    m_ret = '0;

    start = 1'b1; halt_req = 1'b1;
    tick();
    start = 1'b0; halt_req = 1'b0;
    chk("idle_both_halted", 32'(halted), 32'd1);
    chk("idle_both_req", 32'(imem_req), 32'd0);
    resume();

    run_instr(OP_BRN, 0, 0, 1'b1, 16'h0005, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1'b1, 16'h0040, 1'b0);
    run_instr(OP_BRN, 1, 0, 1'b1, 16'hFFFF, 1'b0);
    run_instr(OP_BLT, 0, 0, 1'b0, 16'h1234, 1'b0);
    chk("wrap_addr", 32'(imem_addr), 32'd0);
    run_instr(5'h04, 3, 2, 1'b0, '0, 1'b0);
    run_instr(5'h05, 0, 3, 1'b0, '0, 1'b1);
    resume();
    run_instr(OP_HLT, 1, 0, 1'b0, '0, 1'b0);
    resume();

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30) begin
        op = 5'(OP_BGT + 5'($urandom_range(0, 5)));
      end else if (r < 35) begin
        op = OP_HLT;
      end else begin
        do op = 5'($urandom); while (is_branch(op) || op == OP_HLT);
      end
      hreq = ($urandom_range(0, 9) == 0);
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 16'($urandom), hreq);
      if (op == OP_HLT || hreq) resume();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
